// File: rtl/bcd_counter_scan_if.sv
// Control and display signals of the four-digit BCD counter with multiplexed display.
interface bcd_counter_scan_if;
    logic        enable;
    logic        clear;
    logic [15:0] count_bcd;
    logic [3:0]  digit;
    logic [3:0]  anode;
    logic        carry_out;

    modport master (
        output enable, clear,
        input  count_bcd, digit, anode, carry_out
    );

    modport slave (
        input  enable, clear,
        output count_bcd, digit, anode, carry_out
    );
endinterface

// File: rtl/bcd_counter_scan.sv
// Four-digit BCD event counter with prescaler, wrap carry pulse and a
// time-multiplexed digit/anode scan for a common-anode seven-segment display.
module bcd_counter_scan #(
    parameter int TICK_DIV = 50000000,
    parameter int SCAN_DIV = 50000
) (
    input  logic               clk,
    input  logic               reset,
    bcd_counter_scan_if.slave  bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    logic [PW-1:0] pre_q;
    logic [SW-1:0] scan_q;
    logic [1:0]    sel_q;
    logic [15:0]   count_q;
    logic [15:0]   count_inc;
    logic          carry_q;
    logic          tick;

    assign tick = bus.enable && (pre_q == PRE_LAST);

    // Ripple the decimal carry through all four digits so 0199 -> 0200 in one edge.
    always_comb begin : bcd_inc
        logic c;
        count_inc = count_q;
        c         = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (count_q[4*i +: 4] >= 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    c                   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q   <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
        end else if (bus.clear) begin
            pre_q   <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
        end else begin
            carry_q <= tick && (count_q == 16'h9999);
            if (bus.enable) begin
                pre_q <= (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
            end
            if (tick) begin
                count_q <= count_inc;
            end
        end
    end

    // Scan runs free of enable and clear so the display never freezes on one digit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_q <= '0;
            sel_q  <= 2'd0;
        end else if (scan_q == SCAN_LAST) begin
            scan_q <= '0;
            sel_q  <= sel_q + 2'd1;
        end else begin
            scan_q <= scan_q + SW'(1);
        end
    end

    always_comb begin
        bus.anode = 4'b1110;
        bus.digit = count_q[3:0];
        case (sel_q)
            2'd0: begin bus.anode = 4'b1110; bus.digit = count_q[3:0];   end
            2'd1: begin bus.anode = 4'b1101; bus.digit = count_q[7:4];   end
            2'd2: begin bus.anode = 4'b1011; bus.digit = count_q[11:8];  end
            default: begin bus.anode = 4'b0111; bus.digit = count_q[15:12]; end
        endcase
    end

    assign bus.count_bcd = count_q;
    assign bus.carry_out = carry_q;
endmodule

// File: doc/bcd_counter_scan.md
BCD_COUNTER_SCAN -- requirements
Module: bcd_counter_scan

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50000000, giving the number of enabled clk cycles per count increment (legal range 2 or more).
REQ-002 The block SHALL have parameter SCAN_DIV, default 50000, giving the number of clk cycles per display digit step (legal range 2 or more).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port enable, input, 1 bit: counting permitted when high.
REQ-006 The block SHALL have port clear, input, 1 bit: synchronous zeroing of count and prescaler.
REQ-007 The block SHALL have port count_bcd, output, 16 bits: four BCD digits, [15:12] thousands down to [3:0] units.
REQ-008 The block SHALL have port digit, output, 4 bits: BCD value of the currently scanned digit, fed to the seven-segment decoder.
REQ-009 The block SHALL have port anode, output, 4 bits: active-low one-hot digit select; bit 0 is units, bit 3 is thousands.
REQ-010 The block SHALL have port carry_out, output, 1 bit: one-cycle pulse on the 9999->0000 wrap.

Function
REQ-011 The prescaler SHALL count 0..TICK_DIV-1 only while enable=1, hold its value while enable=0, and wrap to 0 after TICK_DIV-1.
REQ-012 A count tick SHALL occur in the cycle in which the prescaler equals TICK_DIV-1 and enable=1.
REQ-013 On a tick, count_bcd SHALL increment by one in BCD, with all digit carries resolved in the same edge (e.g. 0199->0200).
REQ-014 Every digit of count_bcd SHALL always lie in 0..9; no state SHALL ever produce a digit value of 10..15.
REQ-015 On a tick with count_bcd=9999, count_bcd SHALL become 0000 and carry_out SHALL be 1 for exactly the following cycle.
REQ-016 carry_out SHALL be 0 in all other cycles.
REQ-017 clear=1 SHALL, at the next edge, set count_bcd=0000 and prescaler=0 and suppress any coincident tick and carry_out; clear SHALL take priority over enable.
REQ-018 The scan counter SHALL count 0..SCAN_DIV-1 continuously, independent of enable and clear.
REQ-019 On scan-counter wrap, the 2-bit select sel SHALL advance 0->1->2->3->0.
REQ-020 anode SHALL equal ~(1<<sel): sel=0 gives 1110, 1 gives 1101, 2 gives 1011, 3 gives 0111.
REQ-021 digit SHALL equal count_bcd[4*sel+3:4*sel], combinationally following both sel and count_bcd.
REQ-022 anode SHALL have exactly one bit low at all times, including during and after reset.
REQ-023 Count latency SHALL be: the first increment after reset or clear with enable held high occurs TICK_DIV cycles after enable is first sampled high.

Reset
REQ-024 While reset=1, asynchronously: count_bcd=0000, prescaler=0, scan counter=0, sel=0, anode=1110, digit=0000, carry_out=0.
REQ-025 Reset asserted mid-count or mid-scan SHALL discard all state immediately, with no pending carry_out emitted after release.
REQ-026 After reset deasserts, operation SHALL resume from the reset state on the next rising edge.

Verification (TICK_DIV=4, SCAN_DIV=2)
REQ-027 Reset then enable=1 for 40 cycles -> count_bcd=0x0010; increments exactly every 4 cycles; first increment 4 cycles after enable.
REQ-028 Preload via ticks to 0x0099, then one tick -> 0x0100 at once; no intermediate 0x009A value is ever seen.
REQ-029 Count to 0x9999, then one tick -> 0x0000 and carry_out high for exactly 1 cycle; no other carry_out pulses over the full 10000-count run.
REQ-030 enable toggled low for 7 cycles mid-prescale -> prescaler holds; the next tick is delayed by exactly 7 cycles. clear coincident with a tick at 9999 -> 0x0000 with carry_out=0.
REQ-031 count_bcd=0x1234, free scan -> (anode, digit) cycles (1110,4), (1101,3), (1011,2), (0111,1), each held 2 cycles, then repeats.
REQ-032 reset pulsed asynchronously between edges at count 0x0567 -> immediate 0x0000, anode=1110, carry_out=0; counting restarts cleanly after release.
